// File: rtl/mac_accumulate_if.sv
// mac_accumulate_if: operand/result handshake bundle for mac_accumulate.
// Upstream drives in_*, clear and out_ready; the MAC drives the rest.
interface mac_accumulate_if;
  logic              in_valid;
  logic              in_ready;
  logic signed [3:0] in_a;
  logic signed [3:0] in_b;
  logic              in_last;
  logic              clear;
  logic              out_valid;
  logic              out_ready;
  logic signed [7:0] acc;
  logic signed [7:0] product;
  logic              overflow;

  modport master (
    output in_valid, in_a, in_b, in_last,
    output clear, out_ready,
    input  in_ready, out_valid,
    input  acc, product, overflow
  );

  modport slave (
    input  in_valid, in_a, in_b, in_last,
    input  clear, out_ready,
    output in_ready, out_valid,
    output acc, product, overflow
  );
endinterface

// File: rtl/mac_accumulate.sv
// mac_accumulate: 4x4 signed shift-add multiply, 8-bit accumulate.
// Ports: clock, reset_n (sync, active low), bus (mac_accumulate_if.slave).
// Build option: MAC_SATURATE_EN clamps the accumulator instead of wrapping.
module mac_accumulate (
  input logic             clock,
  input logic             reset_n,
  mac_accumulate_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    MULT,
    ACC,
    DONE
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic signed [3:0] r_a;
  logic signed [3:0] r_b;
  logic              r_last;
  logic [1:0]        r_step;
  logic signed [7:0] r_pp;
  logic signed [7:0] r_product;
  logic signed [7:0] r_acc;
  logic              r_ovf;

  logic signed [7:0] w_a_ext;
  logic signed [7:0] w_shift;
  logic signed [7:0] w_term;
  logic signed [7:0] w_pp_next;
  logic signed [8:0] w_sum;
  logic              w_sum_ovf;
  logic signed [7:0] w_acc_next;

  assign w_a_ext = {{4{r_a[3]}}, r_a};
  assign w_shift = w_a_ext << r_step;

  // Bit 3 of the multiplier carries weight -8, so its term is subtracted.
  always_comb begin
    w_term = '0;
    if (r_b[r_step]) begin
      if (r_step == 2'd3) w_term = -w_shift;
      else                w_term = w_shift;
    end
  end

  assign w_pp_next = r_pp + w_term;

  assign w_sum = {r_acc[7], r_acc}
               + {r_product[7], r_product};
  assign w_sum_ovf = w_sum[8] ^ w_sum[7];

`ifdef MAC_SATURATE_EN
  always_comb begin
    w_acc_next = w_sum[7:0];
    if (w_sum_ovf) begin
      if (w_sum[8]) w_acc_next = 8'sh80;
      else          w_acc_next = 8'sh7F;
    end
  end
`else
  assign w_acc_next = w_sum[7:0];
`endif

  always_ff @(posedge clock) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (bus.clear) begin
      w_next = IDLE;
    end else begin
      unique case (1'b1)
        (r_state == IDLE):
          if (bus.in_valid) w_next = MULT;
        (r_state == MULT):
          if (r_step == 2'd3) w_next = ACC;
        (r_state == ACC):
          w_next = r_last ? DONE : IDLE;
        (r_state == DONE):
          if (bus.out_ready) w_next = IDLE;
        default: w_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_a       <= '0;
      r_b       <= '0;
      r_last    <= 1'b0;
      r_step    <= '0;
      r_pp      <= '0;
      r_product <= '0;
      r_acc     <= '0;
      r_ovf     <= 1'b0;
    end else if (bus.clear) begin
      r_step <= '0;
      r_pp   <= '0;
      r_acc  <= '0;
      r_ovf  <= 1'b0;
    end else begin
      unique case (1'b1)
        (r_state == IDLE): begin
          if (bus.in_valid) begin
            r_a    <= bus.in_a;
            r_b    <= bus.in_b;
            r_last <= bus.in_last;
            r_step <= '0;
            r_pp   <= '0;
          end
        end
        (r_state == MULT): begin
          r_pp   <= w_pp_next;
          r_step <= r_step + 2'd1;
          if (r_step == 2'd3) r_product <= w_pp_next;
        end
        (r_state == ACC): begin
          r_acc <= w_acc_next;
          if (w_sum_ovf) r_ovf <= 1'b1;
        end
        (r_state == DONE): begin
          if (bus.out_ready) begin
            r_acc <= '0;
            r_ovf <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == IDLE);
  assign bus.out_valid = (r_state == DONE);
  assign bus.acc       = r_acc;
  assign bus.product   = r_product;
  assign bus.overflow  = r_ovf;

endmodule

// File: tb/tb_mac_accumulate.sv
// tb_mac_accumulate: directed and random stimulus for mac_accumulate,
// checked every cycle against a transaction-level model.
module tb_mac_accumulate;

  logic clock = 1'b0;
  logic reset_n = 1'b0;

  mac_accumulate_if bus ();

  mac_accumulate dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(string nm, logic signed [31:0] act,
                     logic signed [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Model: a pair is taken when idle; its product appears 4 edges later
  // and the accumulator one edge after that.
  int m_cnt  = 0;
  int m_acc  = 0;
  int m_prod = 0;
  int m_a    = 0;
  int m_b    = 0;
  bit m_ovf  = 0;
  bit m_done = 0;
  bit m_last = 0;
  bit started = 0;

  function automatic int fold(int s);
`ifdef MAC_SATURATE_EN
    if (s > 127)  return 127;
    if (s < -128) return -128;
    return s;
`else
    if (s > 127)  return s - 256;
    if (s < -128) return s + 256;
    return s;
`endif
  endfunction

  always @(posedge clock) begin
    started = 1;
    if (!reset_n) begin
      m_cnt = 0; m_acc = 0; m_prod = 0;
      m_ovf = 0; m_done = 0;
    end else if (bus.clear) begin
      m_cnt = 0; m_acc = 0; m_ovf = 0; m_done = 0;
    end else if (m_done) begin
      if (bus.out_ready) begin
        m_done = 0; m_acc = 0; m_ovf = 0;
      end
    end else if (m_cnt == 0) begin
      if (bus.in_valid) begin
        m_a = int'(bus.in_a);
        m_b = int'(bus.in_b);
        m_last = bus.in_last;
        m_cnt = 5;
      end
    end else begin
      m_cnt--;
      if (m_cnt == 1) m_prod = m_a * m_b;
      if (m_cnt == 0) begin
        if (m_acc + m_prod > 127 || m_acc + m_prod < -128)
          m_ovf = 1;
        m_acc = fold(m_acc + m_prod);
        m_done = m_last;
      end
    end
  end

  always @(negedge clock) begin
    if (started) begin
      chk("in_ready", {31'd0, bus.in_ready},
          (m_cnt == 0 && !m_done) ? 1 : 0);
      chk("out_valid", {31'd0, bus.out_valid}, m_done ? 1 : 0);
      chk("acc", 32'(bus.acc), m_acc);
      chk("product", 32'(bus.product), m_prod);
      chk("overflow", {31'd0, bus.overflow}, m_ovf ? 1 : 0);
    end
  end

  task automatic send(int a, int b, bit last);
    int k = 0;
    while (!bus.in_ready && k < 50) begin
      @(negedge clock);
      k++;
    end
    if (k >= 50) chk("send_timeout", 0, 1);
    bus.in_a     = 4'(a);
    bus.in_b     = 4'(b);
    bus.in_last  = last;
    bus.in_valid = 1'b1;
    @(negedge clock);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic take();
    bus.out_ready = 1'b1;
    @(negedge clock);
    bus.out_ready = 1'b0;
  endtask

  int exp_sat;

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_last   = 1'b0;
    bus.clear     = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_acc", 32'(bus.acc), 0);
    chk("rst_out_valid", {31'd0, bus.out_valid}, 0);
    reset_n = 1'b1;
    @(negedge clock);
    chk("ready_after_rst", {31'd0, bus.in_ready}, 1);

    send(2, 3, 0);
    repeat (5) @(negedge clock);
    chk("p1_acc", 32'(bus.acc), 6);
    chk("p1_prod", 32'(bus.product), 6);
    send(4, -5, 1);
    repeat (5) @(negedge clock);
    chk("p2_acc", 32'(bus.acc), -14);
    chk("p2_prod", 32'(bus.product), -20);
    chk("p2_model_acc", m_acc, -14);
    chk("p2_out_valid", {31'd0, bus.out_valid}, 1);
    chk("p2_ovf", {31'd0, bus.overflow}, 0);
    take();

    send(-8, -8, 1);
    for (int i = 1; i <= 5; i++) begin
      @(negedge clock);
      chk("lat_in_ready", {31'd0, bus.in_ready}, 0);
      if (i < 5) chk("lat_out_valid", {31'd0, bus.out_valid}, 0);
    end
    chk("lat_acc", 32'(bus.acc), 64);
    chk("lat_prod", 32'(bus.product), 64);
    chk("lat_out_valid_e5", {31'd0, bus.out_valid}, 1);
    take();

`ifdef MAC_SATURATE_EN
    exp_sat = 127;
`else
    exp_sat = -128;
`endif
    send(-8, -8, 0);
    repeat (5) @(negedge clock);
    send(-8, -8, 1);
    repeat (5) @(negedge clock);
    chk("ovf_acc", 32'(bus.acc), exp_sat);
    chk("ovf_flag", {31'd0, bus.overflow}, 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      chk("hold_acc", 32'(bus.acc), exp_sat);
      chk("hold_valid", {31'd0, bus.out_valid}, 1);
      chk("hold_ready", {31'd0, bus.in_ready}, 0);
    end
    take();
    chk("take_acc", 32'(bus.acc), 0);
    chk("take_ovf", {31'd0, bus.overflow}, 0);
    chk("take_ready", {31'd0, bus.in_ready}, 1);

    send(7, 7, 1);
    @(negedge clock);
    bus.clear = 1'b1;
    @(negedge clock);
    bus.clear = 1'b0;
    chk("clr_acc", 32'(bus.acc), 0);
    chk("clr_ready", {31'd0, bus.in_ready}, 1);
    repeat (6) @(negedge clock);
    chk("clr_no_acc", 32'(bus.acc), 0);
    chk("clr_no_valid", {31'd0, bus.out_valid}, 0);
    chk("clr_prod_kept", 32'(bus.product), 64);

    send(3, 3, 0);
    repeat (4) @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    chk("mrst_acc", 32'(bus.acc), 0);
    chk("mrst_prod", 32'(bus.product), 0);
    chk("mrst_ovf", {31'd0, bus.overflow}, 0);
    chk("mrst_valid", {31'd0, bus.out_valid}, 0);
    reset_n = 1'b1;
    @(negedge clock);
    chk("mrst_ready", {31'd0, bus.in_ready}, 1);
    send(1, 1, 1);
    repeat (5) @(negedge clock);
    chk("post_rst_acc", 32'(bus.acc), 1);
    chk("post_rst_valid", {31'd0, bus.out_valid}, 1);
    take();

    for (int i = 0; i < 600; i++) begin
      bus.in_valid  = 1'($urandom_range(0, 1));
      bus.in_a      = 4'($urandom);
      bus.in_b      = 4'($urandom);
      bus.in_last   = ($urandom_range(0, 3) == 0);
      bus.out_ready = 1'($urandom_range(0, 1));
      bus.clear     = ($urandom_range(0, 40) == 0);
      @(negedge clock);
    end
    bus.in_valid  = 1'b0;
    bus.clear     = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clock);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
